// File: rtl/gekkio_vector_checker.sv
// gekkio_vector_checker
//   Replay-and-compare engine for the decoder cross-check flow. It sweeps the
//   15-bit decoder stimulus index and drives it to the sequencer mock. After
//   each index change it waits SETTLE cycles, then accepts one expected
//   {stage1, stage2, stage3} record over a valid/ready stream. That record is
//   compared against the live decoder outputs, and mismatch statistics are
//   accumulated.
//
// Ports
//   CLK, RESET          rising-edge clock, asynchronous active-high reset
//   start               pulse; begins a sweep from IDLE or DONE
//   counter             stimulus index (bit0 = writeback/CLK5, bit1 = data_lsb)
//   obs_stage1..3       live decoder outputs (lsb-first gekkio order)
//   exp_valid/exp_ready expected-record handshake
//   exp_stage1..3       expected decoder outputs for the current index
//   busy, done          sweep in progress / sweep complete (held)
//   err_count           saturating count of mismatching records
//   first_err_idx       index of the first mismatching record
//   first_err_stage     {stage3, stage2, stage1} mismatch flags of that record
//   any_err             a mismatch has been recorded
module gekkio_vector_checker #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned LAST   = 32767,
  parameter int unsigned ERRW   = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  output logic [14:0]       counter,
  input  logic [103:0]      obs_stage1,
  input  logic [37:0]       obs_stage2,
  input  logic [68:0]       obs_stage3,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [103:0]      exp_stage1,
  input  logic [37:0]       exp_stage2,
  input  logic [68:0]       exp_stage3,
  output logic              busy,
  output logic              done,
  output logic [ERRW-1:0]   err_count,
  output logic [14:0]       first_err_idx,
  output logic [2:0]        first_err_stage,
  output logic              any_err
);

  localparam int unsigned SW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);
  localparam logic [14:0]   LAST_IDX    = 15'(LAST);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CMP,
    ST_DONE
  } state_t;

  state_t          state, state_n;
  logic [SW-1:0]   settle_cnt, settle_n;
  logic [14:0]     counter_n;
  logic            ready_n, busy_n, done_n, any_n;
  logic [ERRW-1:0] err_n;
  logic [14:0]     fidx_n;
  logic [2:0]      fstage_n;
  logic [2:0]      neq;
  logic            handshake;

  assign neq = {exp_stage3 != obs_stage3,
                exp_stage2 != obs_stage2,
                exp_stage1 != obs_stage1};
  assign handshake = exp_valid & exp_ready;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state           <= ST_IDLE;
      settle_cnt      <= '0;
      counter         <= '0;
      exp_ready       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err_count       <= '0;
      first_err_idx   <= '0;
      first_err_stage <= '0;
      any_err         <= 1'b0;
    end else begin
      state           <= state_n;
      settle_cnt      <= settle_n;
      counter         <= counter_n;
      exp_ready       <= ready_n;
      busy            <= busy_n;
      done            <= done_n;
      err_count       <= err_n;
      first_err_idx   <= fidx_n;
      first_err_stage <= fstage_n;
      any_err         <= any_n;
    end
  end

  always_comb begin
    state_n   = state;
    settle_n  = settle_cnt;
    counter_n = counter;
    ready_n   = exp_ready;
    busy_n    = busy;
    done_n    = done;
    err_n     = err_count;
    fidx_n    = first_err_idx;
    fstage_n  = first_err_stage;
    any_n     = any_err;

    case (state)
      ST_IDLE, ST_DONE: begin
        ready_n = 1'b0;
        if (start) begin
          counter_n = '0;
          err_n     = '0;
          fidx_n    = '0;
          fstage_n  = '0;
          any_n     = 1'b0;
          done_n    = 1'b0;
          busy_n    = 1'b1;
          settle_n  = SETTLE_LOAD;
          state_n   = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        ready_n = 1'b0;
        if (settle_cnt == '0) begin
          // ready is registered, so raising it here makes it valid on CMP entry
          ready_n = 1'b1;
          state_n = ST_CMP;
        end else begin
          settle_n = settle_cnt - 1'b1;
        end
      end

      ST_CMP: begin
        if (handshake) begin
          if (neq != 3'b000) begin
            if (err_count != '1) err_n = err_count + ERRW'(1);
            if (!any_err) begin
              fidx_n   = counter;
              fstage_n = neq;
              any_n    = 1'b1;
            end
          end
          ready_n = 1'b0;
          if (counter == LAST_IDX) begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = ST_DONE;
          end else begin
            counter_n = counter + 15'd1;
            settle_n  = SETTLE_LOAD;
            state_n   = ST_SETTLE;
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_gekkio_vector_checker.sv
// tb_gekkio_vector_checker
//   Bench for gekkio_vector_checker. The bench drives two instances from the
//   same stimulus: one with a 16-bit error counter and one with a 2-bit error
//   counter. It keeps a transaction-level reference model, which tracks the
//   index, the cycles elapsed since the index changed, and the record
//   statistics. A single negedge process compares every output of both
//   instances against that model.
module tb_gekkio_vector_checker;

  localparam int unsigned SETTLE = 2;
  localparam int unsigned LAST   = 7;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         start = 1'b0;
  logic         exp_valid = 1'b0;
  logic [103:0] obs1 = '0, exp1 = '0;
  logic [37:0]  obs2 = '0, exp2 = '0;
  logic [68:0]  obs3 = '0, exp3 = '0;

  logic [14:0]  a_counter, b_counter;
  logic         a_ready, b_ready, a_busy, b_busy, a_done, b_done, a_any, b_any;
  logic [15:0]  a_err;
  logic [1:0]   b_err;
  logic [14:0]  a_fidx, b_fidx;
  logic [2:0]   a_fst, b_fst;

  gekkio_vector_checker #(.SETTLE(SETTLE), .LAST(LAST), .ERRW(16)) dut_a (
    .CLK(CLK), .RESET(RESET), .start(start), .counter(a_counter),
    .obs_stage1(obs1), .obs_stage2(obs2), .obs_stage3(obs3),
    .exp_valid(exp_valid), .exp_ready(a_ready),
    .exp_stage1(exp1), .exp_stage2(exp2), .exp_stage3(exp3),
    .busy(a_busy), .done(a_done), .err_count(a_err),
    .first_err_idx(a_fidx), .first_err_stage(a_fst), .any_err(a_any)
  );

  gekkio_vector_checker #(.SETTLE(SETTLE), .LAST(LAST), .ERRW(2)) dut_b (
    .CLK(CLK), .RESET(RESET), .start(start), .counter(b_counter),
    .obs_stage1(obs1), .obs_stage2(obs2), .obs_stage3(obs3),
    .exp_valid(exp_valid), .exp_ready(b_ready),
    .exp_stage1(exp1), .exp_stage2(exp2), .exp_stage3(exp3),
    .busy(b_busy), .done(b_done), .err_count(b_err),
    .first_err_idx(b_fidx), .first_err_stage(b_fst), .any_err(b_any)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  // A sweep is a list of indices 0..LAST. Each index becomes acceptable once
  // it has been stable for SETTLE cycles. An accepted record advances the
  // index. Statistics are derived from the exp/obs data on acceptance.
  int       m_counter = 0;
  int       m_age = 0;
  int       m_err = 0;
  int       m_first_idx = 0;
  int       m_hs = 0;
  bit       m_busy = 0, m_done = 0, m_any = 0;
  bit [2:0] m_first_stage = 0;
  bit [2:0] m_d;

  function automatic bit m_ready();
    return m_busy && (m_age >= int'(SETTLE));
  endfunction

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_counter = 0; m_age = 0; m_err = 0; m_first_idx = 0;
      m_busy = 0; m_done = 0; m_any = 0; m_first_stage = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_counter = 0; m_age = 0; m_err = 0; m_first_idx = 0;
        m_any = 0; m_first_stage = 0; m_done = 0; m_busy = 1;
      end
    end else if (m_ready() && exp_valid) begin
      m_d = {exp3 != obs3, exp2 != obs2, exp1 != obs1};
      m_hs++;
      if (m_d != 3'b000) begin
        m_err++;
        if (!m_any) begin
          m_any = 1; m_first_idx = m_counter; m_first_stage = m_d;
        end
      end
      if (m_counter == int'(LAST)) begin
        m_busy = 0; m_done = 1;
      end else begin
        m_counter++; m_age = 0;
      end
    end else if (!m_ready()) begin
      m_age++;
    end
  end

  bit chk_en = 0;

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("counter",   64'(a_counter), 64'(m_counter));
      chk("exp_ready", 64'(a_ready),   64'(m_ready()));
      chk("busy",      64'(a_busy),    64'(m_busy));
      chk("done",      64'(a_done),    64'(m_done));
      chk("err_count", 64'(a_err),     64'((m_err > 65535) ? 65535 : m_err));
      chk("first_idx", 64'(a_fidx),    64'(m_first_idx));
      chk("first_stg", 64'(a_fst),     64'(m_first_stage));
      chk("any_err",   64'(a_any),     64'(m_any));
      chk("b_counter", 64'(b_counter), 64'(m_counter));
      chk("b_ready",   64'(b_ready),   64'(m_ready()));
      chk("b_busy",    64'(b_busy),    64'(m_busy));
      chk("b_done",    64'(b_done),    64'(m_done));
      chk("b_err",     64'(b_err),     64'((m_err > 3) ? 3 : m_err));
      chk("b_fidx",    64'(b_fidx),    64'(m_first_idx));
      chk("b_fstg",    64'(b_fst),     64'(m_first_stage));
      chk("b_any",     64'(b_any),     64'(m_any));
    end
  end

  // ---------------- data driver ----------------
  // emode: 0 exp==obs, 1 directed flips, 2 every record wrong, 3 random flips
  int emode = 0;
  bit vrand = 0;
  bit valid_block = 0;

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(posedge CLK) begin
    logic [127:0] t1, t2, t3;
    #2;
    t1 = r128(); t2 = r128(); t3 = r128();
    obs1 = t1[103:0]; obs2 = t2[37:0]; obs3 = t3[68:0];
    exp1 = obs1; exp2 = obs2; exp3 = obs3;
    case (emode)
      1: begin
        if (m_counter == 3) exp2[5] = ~exp2[5];
        if (m_counter == 5) exp3[0] = ~exp3[0];
      end
      2: begin
        case ($urandom_range(0, 2))
          0: exp1[$urandom_range(0, 103)] = ~exp1[$urandom_range(0, 103)];
          1: exp2 = ~exp2;
          default: exp3[$urandom_range(0, 68)] = 1'b1 ^ obs3[$urandom_range(0, 68)];
        endcase
        // guarantee a mismatch regardless of which bits the random picks hit
        if (exp1 == obs1 && exp3 == obs3 && exp2 == obs2) exp1 = ~obs1;
      end
      3: begin
        if ($urandom_range(0, 3) == 0) exp1[$urandom_range(0, 103)] = ~exp1[$urandom_range(0, 103)];
        if ($urandom_range(0, 3) == 0) exp2[$urandom_range(0, 37)]  = ~exp2[$urandom_range(0, 37)];
        if ($urandom_range(0, 3) == 0) exp3[$urandom_range(0, 68)]  = ~exp3[$urandom_range(0, 68)];
      end
      default: ;
    endcase
    if (valid_block) exp_valid = 1'b0;
    else if (vrand)  exp_valid = ($urandom_range(0, 3) != 0);
    else             exp_valid = 1'b1;
  end

  // ---------------- sequencing helpers ----------------
  task automatic start_pulse();
    @(posedge CLK); #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int n);
    n = 0;
    while (!a_done && n < 500) begin
      @(posedge CLK); #1;
      n++;
    end
    chk(nm, 64'(a_done), 64'd1);
  endtask

  task automatic wait_index(input string nm, input int idx, input bit need_ready);
    int n;
    n = 0;
    while (!(m_counter == idx && (!need_ready || a_ready)) && n < 500) begin
      @(posedge CLK); #1;
      n++;
    end
    chk(nm, 64'(a_counter), 64'(idx));
  endtask

  int n, hs0;

  initial begin
    #1 RESET = 1'b1;
    @(posedge CLK); #1;
    chk_en = 1;
    @(posedge CLK); #1 RESET = 1'b0;
    // reset state literals
    chk("rst_counter", 64'(a_counter), 64'd0);
    chk("rst_busy",    64'(a_busy),    64'd0);
    chk("rst_err",     64'(a_err),     64'd0);

    // clean sweep: 8 records, 24 cycles
    emode = 0; vrand = 0;
    hs0 = m_hs;
    start_pulse();
    wait_done("t1_done", n);
    chk("t1_cycles",     64'(n),           64'd24);
    chk("t1_handshakes", 64'(m_hs - hs0),  64'd8);
    chk("t1_counter",    64'(a_counter),   64'd7);
    chk("t1_any",        64'(a_any),       64'd0);

    // directed mismatches on records 3 and 5
    emode = 1;
    start_pulse();
    wait_done("t2_done", n);
    chk("t2_err",   64'(a_err),  64'd2);
    chk("t2_fidx",  64'(a_fidx), 64'd3);
    chk("t2_fstg",  64'(a_fst),  64'b010);
    chk("t2_any",   64'(a_any),  64'd1);

    // restart from DONE clears errors; start during SETTLE is ignored
    emode = 0;
    start_pulse();
    chk("t6_err",     64'(a_err),     64'd0);
    chk("t6_done",    64'(a_done),    64'd0);
    chk("t6_busy",    64'(a_busy),    64'd1);
    chk("t6_counter", 64'(a_counter), 64'd0);
    start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    chk("t6_ign_counter", 64'(a_counter), 64'd0);
    chk("t6_ign_busy",    64'(a_busy),    64'd1);
    wait_done("t6_done2", n);

    // exp_valid withheld for 10 cycles in CMP at index 2
    start_pulse();
    wait_index("t3_reach2", 2, 1'b0);
    valid_block = 1;
    wait_index("t3_ready2", 2, 1'b1);
    repeat (10) begin @(posedge CLK); #1; end
    chk("t3_hold_counter", 64'(a_counter), 64'd2);
    chk("t3_hold_ready",   64'(a_ready),   64'd1);
    valid_block = 0;
    wait_done("t3_done", n);
    chk("t3_err", 64'(a_err), 64'd0);

    // every record wrong: 2-bit counter saturates
    emode = 2;
    start_pulse();
    wait_done("t4_done", n);
    chk("t4_b_err", 64'(b_err),  64'd3);
    chk("t4_a_err", 64'(a_err),  64'd8);
    chk("t4_fidx",  64'(a_fidx), 64'd0);

    // async reset mid-sweep at index 4 while ready
    emode = 3;
    start_pulse();
    wait_index("t5_reach4", 4, 1'b1);
    RESET = 1'b1;
    #1;
    chk("t5_counter", 64'(a_counter), 64'd0);
    chk("t5_ready",   64'(a_ready),   64'd0);
    chk("t5_busy",    64'(a_busy),    64'd0);
    chk("t5_done",    64'(a_done),    64'd0);
    chk("t5_err",     64'(a_err),     64'd0);
    chk("t5_any",     64'(a_any),     64'd0);
    @(posedge CLK); #1 RESET = 1'b0;
    emode = 0;
    start_pulse();
    chk("t5_restart_counter", 64'(a_counter), 64'd0);
    chk("t5_restart_busy",    64'(a_busy),    64'd1);
    wait_done("t5_done", n);

    // random traffic with random start pulses
    emode = 3; vrand = 1;
    repeat (2000) begin
      @(posedge CLK); #1 start = ($urandom_range(0, 15) == 0);
    end
    start = 1'b0;
    wait_done("rand_done", n);
    @(posedge CLK); #1;
    chk_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
